// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: FWFT capture of retired register-write records with sequence tags and drop accounting.
// Optional COMMIT_TRACE_X0_FILTER_EN: commits writing x0 are ignored entirely.
module commit_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_data,
  output logic [31:0]              out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] seq;
  } rec_t;
  rec_t        mem [DEPTH];
  rec_t        head;
  logic [AW:0] wptr, rptr;
  logic [31:0] seq_ctr;
  logic        full, empty, eligible, pop, push, drop;
`ifdef COMMIT_TRACE_X0_FILTER_EN
  assign eligible = commit_valid && (commit_rd != 5'd0);
`else
  assign eligible = commit_valid;
`endif
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign out_valid = !empty;
  assign pop   = out_valid && out_ready;
  assign push  = eligible && (!full || pop);
  assign drop  = eligible && full && !pop;
  assign level = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];
  // Fields read as zero while empty so reset and clear present a clean bus.
  always_comb begin
    out_pc   = out_valid ? head.pc   : 32'd0;
    out_rd   = out_valid ? head.rd   : 5'd0;
    out_data = out_valid ? head.data : 32'd0;
    out_seq  = out_valid ? head.seq  : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr[AW-1:0]] <= {commit_pc, commit_rd, commit_data, seq_ctr};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      seq_ctr    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      seq_ctr    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wptr    <= wptr + (AW+1)'(1);
        seq_ctr <= seq_ctr + 32'd1;
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
      end
    end
  end
endmodule
